// File: rtl/ysyx_22050039_fetch_unit.sv
// Instruction fetch stage: holds the PC, keeps one imem fetch in flight at a time, and hands
// {inst, inst_pc} to decode. Redirects replace the PC and squash any response that is now stale.
module ysyx_22050039_fetch_unit #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    input  logic                halt,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [INST_LEN-1:0] imem_rsp_data,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INST_LEN-1:0] inst,
    output logic [XLEN-1:0]     inst_pc,
    output logic [XLEN-1:0]     fetch_cnt
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t              r_state, w_state_nxt;
    logic [XLEN-1:0]     r_pc, w_pc_nxt;
    logic [XLEN-1:0]     r_inst_pc, w_inst_pc_nxt;
    logic [XLEN-1:0]     r_cnt, w_cnt_nxt;
    logic [INST_LEN-1:0] r_inst, w_inst_nxt;
    logic                r_stale, w_stale_nxt;

    logic                w_req_fire;
    logic                w_dec_fire;
    logic [XLEN-1:0]     w_redir_pc;

    // Gating with rst keeps the request low during reset even though state already reads S_REQ.
    assign imem_req_valid = rst & (r_state == S_REQ) & ~halt;
    assign inst_valid     = (r_state == S_HOLD);
    assign imem_addr      = r_pc;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign fetch_cnt      = r_cnt;

    assign w_req_fire = imem_req_valid & imem_req_ready;
    assign w_dec_fire = inst_valid & inst_ready;
    assign w_redir_pc = redirect_pc & ~XLEN'(3);

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = redirect_valid ? w_redir_pc : r_pc;
        w_inst_pc_nxt = r_inst_pc;
        w_inst_nxt    = r_inst;
        w_cnt_nxt     = r_cnt;
        w_stale_nxt   = r_stale;
        unique case (r_state)
            S_REQ: begin
                if (w_req_fire) begin
                    w_state_nxt = S_WAIT;
                    w_stale_nxt = redirect_valid;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (r_stale || redirect_valid) begin
                        w_stale_nxt = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_inst_nxt    = imem_rsp_data;
                        w_inst_pc_nxt = r_pc;
                        w_state_nxt   = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    w_stale_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                // A consumed instruction still counts when a redirect lands in the same cycle.
                if (w_dec_fire) begin
                    w_cnt_nxt = r_cnt + XLEN'(1);
                    if (!redirect_valid)
                        w_pc_nxt = r_pc + XLEN'(4);
                end
                if (w_dec_fire || redirect_valid)
                    w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_PC;
            r_inst_pc <= '0;
            r_inst    <= '0;
            r_cnt     <= '0;
            r_stale   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_inst_pc <= w_inst_pc_nxt;
            r_inst    <= w_inst_nxt;
            r_cnt     <= w_cnt_nxt;
            r_stale   <= w_stale_nxt;
        end
    end

endmodule

// File: tb/tb_ysyx_22050039_fetch_unit.sv
// Scoreboard bench for the fetch unit: stimulus pushes expected fetch addresses and decoded
// instructions; monitors pop and compare on every request and decode handshake.
module tb_ysyx_22050039_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [63:0] fetch_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int rsp_delay = 1;

    logic [63:0] exp_addr_q[$];
    logic [95:0] exp_inst_q[$];

    always #5 clk = ~clk;

    ysyx_22050039_fetch_unit dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .fetch_cnt(fetch_cnt)
    );

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input logic [63:0] n, input string nm);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (fetch_cnt == n) ok = 1;
        end
        chk(nm, 96'(ok), 96'd1);
    endtask

    task automatic wait_valid(input string nm);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (inst_valid) ok = 1;
        end
        chk(nm, 96'(ok), 96'd1);
    endtask

    // Memory model: one response per accepted request, rsp_delay cycles later,
    // data = {addr[15:0], 16'h0013}. It keeps a pending response across reset on purpose.
    initial begin
        bit          fire, pend;
        int          pcnt;
        logic [63:0] faddr, paddr;
        pend = 0; pcnt = 0; paddr = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            fire  = rst && imem_req_valid && imem_req_ready;
            faddr = imem_addr;
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (fire) begin
                pend = 1; pcnt = rsp_delay; paddr = faddr;
            end
            if (pend) begin
                if (pcnt <= 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = {paddr[15:0], 16'h0013};
                    pend = 0;
                end else begin
                    pcnt--;
                end
            end
        end
    end

    // Request monitor
    always @(negedge clk) begin
        if (rst && imem_req_valid && imem_req_ready) begin
            if (exp_addr_q.size() == 0) chk("unexpected_req", {32'd0, imem_addr}, 96'd0);
            else chk("req_addr", {32'd0, imem_addr}, {32'd0, exp_addr_q.pop_front()});
        end
    end

    // Decode-handshake monitor
    always @(negedge clk) begin
        if (rst && inst_valid && inst_ready) begin
            if (exp_inst_q.size() == 0) chk("unexpected_inst", {inst, inst_pc}, 96'd0);
            else chk("inst_pc_pair", {inst, inst_pc}, exp_inst_q.pop_front());
        end
    end

    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        repeat (3) step();
        chk("rst_req_valid",  96'(imem_req_valid), 96'd0);
        chk("rst_inst_valid", 96'(inst_valid), 96'd0);
        chk("rst_addr",       96'(imem_addr), 96'h8000_0000);
        chk("rst_inst_pc",    96'(inst_pc), 96'd0);
        chk("rst_inst",       96'(inst), 96'd0);
        chk("rst_cnt",        96'(fetch_cnt), 96'd0);

        // 1: back-to-back sequential fetch
        exp_addr_q.push_back(64'h8000_0000); exp_inst_q.push_back({32'h0000_0013, 64'h8000_0000});
        exp_addr_q.push_back(64'h8000_0004); exp_inst_q.push_back({32'h0004_0013, 64'h8000_0004});
        exp_addr_q.push_back(64'h8000_0008); exp_inst_q.push_back({32'h0008_0013, 64'h8000_0008});
        rst = 1'b1;
        wait_cnt(64'd3, "t1_cnt3");
        imem_req_ready = 1'b0;
        chk("t1_next_addr", 96'(imem_addr), 96'h8000_000C);

        // 2: decode backpressure
        exp_addr_q.push_back(64'h8000_000C); exp_inst_q.push_back({32'h000C_0013, 64'h8000_000C});
        inst_ready = 1'b0; imem_req_ready = 1'b1;
        wait_valid("t2_valid");
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 96'(inst_valid), 96'd1);
            chk("t2_hold_data",  {inst, inst_pc}, {32'h000C_0013, 64'h8000_000C});
            chk("t2_no_req",     96'(imem_req_valid), 96'd0);
            chk("t2_cnt",        96'(fetch_cnt), 96'd3);
            step();
        end
        inst_ready = 1'b1;
        wait_cnt(64'd4, "t2_cnt4");
        imem_req_ready = 1'b0;

        // 3: redirect while waiting; the late response must be dropped
        exp_addr_q.push_back(64'h8000_0010);
        rsp_delay = 3; imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_no_inst", 96'(inst_valid), 96'd0);
        end
        chk("t3_req_valid", 96'(imem_req_valid), 96'd1);
        chk("t3_addr",      96'(imem_addr), 96'h8000_0100);
        chk("t3_cnt",       96'(fetch_cnt), 96'd4);

        // 4: unaligned redirect in S_HOLD with decode accepting
        exp_addr_q.push_back(64'h8000_0100); exp_inst_q.push_back({32'h0100_0013, 64'h8000_0100});
        rsp_delay = 1; inst_ready = 1'b0; imem_req_ready = 1'b1;
        wait_valid("t4_valid");
        imem_req_ready = 1'b0; inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0203;
        step();
        redirect_valid = 1'b0;
        chk("t4_cnt",        96'(fetch_cnt), 96'd5);
        chk("t4_inst_valid", 96'(inst_valid), 96'd0);
        chk("t4_addr",       96'(imem_addr), 96'h8000_0200);
        chk("t4_req_valid",  96'(imem_req_valid), 96'd1);

        // 5: halt during S_WAIT
        exp_addr_q.push_back(64'h8000_0200); exp_inst_q.push_back({32'h0200_0013, 64'h8000_0200});
        rsp_delay = 3; imem_req_ready = 1'b1;
        step();
        halt = 1'b1;
        wait_cnt(64'd6, "t5_cnt6");
        for (int i = 0; i < 4; i++) begin
            chk("t5_halt_no_req", 96'(imem_req_valid), 96'd0);
            step();
        end
        chk("t5_addr", 96'(imem_addr), 96'h8000_0204);
        exp_addr_q.push_back(64'h8000_0204); exp_inst_q.push_back({32'h0204_0013, 64'h8000_0204});
        halt = 1'b0;
        wait_cnt(64'd7, "t5_cnt7");
        imem_req_ready = 1'b0;

        // 6: reset in S_WAIT with a late response afterwards
        exp_addr_q.push_back(64'h8000_0208);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0; rst = 1'b0;
        #1;
        chk("t6_rst_req_valid", 96'(imem_req_valid), 96'd0);
        chk("t6_rst_cnt",       96'(fetch_cnt), 96'd0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_no_inst", 96'(inst_valid), 96'd0);
        end
        chk("t6_addr", 96'(imem_addr), 96'h8000_0000);
        chk("t6_cnt",  96'(fetch_cnt), 96'd0);
        chk("t6_idle_req", 96'(imem_req_valid), 96'd1);

        chk("addr_q_empty", 96'(exp_addr_q.size()), 96'd0);
        chk("inst_q_empty", 96'(exp_inst_q.size()), 96'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
